mem_port_arbiter: RTL and testbench

- Shares the single mainMem instance between two requesters: instruction fetch (IF) and load/store data (D).
- Sequences each grant into a mainMem access: a single-word write, or a 1/4/8/16-word read burst.
- Returns burst read data to the owning requester.
- Sits between the pipeline front-end/LSU and mainMem; it is the only master driving mainMem.

---
 rtl/mem_port_arbiter_pkg.sv | 38 +++
 rtl/mem_port_arbiter_rr_arb2.sv | 43 ++++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Purpose  : Shared types, encodings and defaults for the mainMem port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam logic [31:0] MEM_BASE_DEFAULT  = 32'h8002_0000;
    localparam int unsigned MEM_WORDS_DEFAULT = 262144;

    localparam logic [0:1] ACC_1W  = 2'b00;
    localparam logic [0:1] ACC_4W  = 2'b01;
    localparam logic [0:1] ACC_8W  = 2'b10;
    localparam logic [0:1] ACC_16W = 2'b11;

    localparam logic IF = 1'b0;
    localparam logic D  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RD    = 2'd2
    } state_t;

    function automatic logic [0:4] burst_len(input logic [0:1] acc_size);
        logic [0:4] len;
        case (acc_size)
            ACC_1W:  len = 5'd1;
            ACC_4W:  len = 5'd4;
            ACC_8W:  len = 5'd8;
            default: len = 5'd16;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-requester round-robin arbiter; pointer remembers the last winner.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [0:1] i_req,
    input  logic       i_advance,
    output logic [0:1] o_grant,
    output logic       o_pointer
);

    logic r_last;

    // The requester that did not win last time gets priority on a tie.
    always_comb begin
        o_grant = 2'b00;
        if (r_last == D) begin
            o_grant[0] = i_req[0];
            o_grant[1] = i_req[1] & ~i_req[0];
        end else begin
            o_grant[1] = i_req[1];
            o_grant[0] = i_req[0] & ~i_req[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= D;
        end else if (i_advance && (|o_grant)) begin
            r_last <= o_grant[1];
        end
    end

    assign o_pointer = r_last;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares mainMem between IF and D requesters; issues writes and read bursts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEFAULT,
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [0:31] if_addr,
    input  logic [0:1]  if_acc_size,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_wren,
    input  logic [0:31] d_addr,
    input  logic [0:1]  d_acc_size,
    input  logic [0:31] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic        d_err,
    output logic [0:31] rsp_data,
    output logic [0:31] mem_addr,
    output logic [0:31] mem_data_in,
    output logic [0:1]  mem_acc_size,
    output logic        mem_wren,
    output logic        mem_enable,
    input  logic [0:31] mem_data_out,
    input  logic        mem_busy
);

    localparam logic [32:0] c_mem_last = {1'b0, MEM_BASE} + 33'(MEM_WORDS) * 33'd4 - 33'd4;

    state_t      r_state;
    logic [0:4]  r_cnt;
    logic        r_if_gnt, r_d_gnt, r_if_err, r_d_err;
    logic        r_mem_enable, r_mem_wren;
    logic [0:31] r_mem_addr, r_mem_data_in;
    logic [0:1]  r_mem_acc_size;

    logic [0:1]  w_req, w_grant;
    logic        w_ptr, w_sel_d, w_wr, w_arb, w_addr_ok, w_issue;
    logic [0:31] w_addr;
    logic [0:1]  w_size;
    logic [0:4]  w_len;
    logic [0:32] w_last;

    assign w_req   = {if_req, d_req};
    // Arbitration pauses for the err cycle so a held req cannot produce a second err.
    assign w_arb   = (r_state == IDLE) && !mem_busy && (|w_req) && !r_if_err && !r_d_err;
    assign w_sel_d = w_grant[1];
    assign w_addr  = w_sel_d ? d_addr : if_addr;
    assign w_wr    = w_sel_d && d_wren;
    assign w_size  = w_wr ? ACC_1W : (w_sel_d ? d_acc_size : if_acc_size);
    assign w_len   = burst_len(w_size);
    assign w_last  = {1'b0, w_addr} + {26'd0, w_len - 5'd1, 2'b00};
    assign w_addr_ok = (w_addr[30:31] == 2'b00) && (w_addr >= MEM_BASE) && (w_last <= c_mem_last);
    assign w_issue = w_arb && w_addr_ok;

    rr_arb2 u_rr_arb2 (
        .clk       (clock),
        .rst_n     (reset_n),
        .i_req     (w_req),
        .i_advance (w_issue),
        .o_grant   (w_grant),
        .o_pointer (w_ptr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= 5'd0;
            r_if_gnt       <= 1'b0;
            r_d_gnt        <= 1'b0;
            r_if_err       <= 1'b0;
            r_d_err        <= 1'b0;
            r_mem_enable   <= 1'b0;
            r_mem_wren     <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_mem_data_in  <= 32'd0;
            r_mem_acc_size <= ACC_1W;
        end else begin
            r_if_gnt <= 1'b0;
            r_d_gnt  <= 1'b0;
            r_if_err <= 1'b0;
            r_d_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_issue) begin
                        r_state        <= ISSUE;
                        r_if_gnt       <= ~w_sel_d;
                        r_d_gnt        <= w_sel_d;
                        r_mem_enable   <= 1'b1;
                        r_mem_wren     <= w_wr;
                        r_mem_addr     <= w_addr;
                        r_mem_acc_size <= w_size;
                        r_mem_data_in  <= w_wr ? d_wdata : 32'd0;
                    end else if (w_arb) begin
                        r_if_err <= ~w_sel_d;
                        r_d_err  <= w_sel_d;
                    end
                end
                ISSUE: begin
                    if (r_mem_wren) begin
                        r_state      <= IDLE;
                        r_mem_enable <= 1'b0;
                        r_mem_wren   <= 1'b0;
                    end else begin
                        r_state <= RD;
                        r_cnt   <= burst_len(r_mem_acc_size);
                    end
                end
                RD: begin
                    if (!mem_busy) begin
                        r_cnt <= r_cnt - 5'd1;
                        if (r_cnt == 5'd1) begin
                            r_state      <= IDLE;
                            r_mem_enable <= 1'b0;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // After a grant the round-robin pointer names the burst owner.
    assign if_rvalid    = (r_state == RD) && !mem_busy && (w_ptr == IF);
    assign d_rvalid     = (r_state == RD) && !mem_busy && (w_ptr == D);
    assign rsp_data     = mem_data_out;
    assign if_gnt       = r_if_gnt;
    assign d_gnt        = r_d_gnt;
    assign if_err       = r_if_err;
    assign d_err        = r_d_err;
    assign mem_enable   = r_mem_enable;
    assign mem_wren     = r_mem_wren;
    assign mem_addr     = r_mem_addr;
    assign mem_data_in  = r_mem_data_in;
    assign mem_acc_size = r_mem_acc_size;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter with a small mainMem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam logic [31:0] BASE = 32'h8002_0000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req, d_req, d_wren, mem_busy;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [1:0]  if_acc_size, d_acc_size;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] rsp_data, mem_addr, mem_data_in, mem_data_out;
    logic [1:0]  mem_acc_size;
    logic        mem_wren, mem_enable;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mem_port_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_acc_size(if_acc_size),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_err(if_err),
        .d_req(d_req), .d_wren(d_wren), .d_addr(d_addr), .d_acc_size(d_acc_size),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_err(d_err),
        .rsp_data(rsp_data), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_acc_size(mem_acc_size), .mem_wren(mem_wren), .mem_enable(mem_enable),
        .mem_data_out(mem_data_out), .mem_busy(mem_busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // mainMem model: 64-word window indexed by address bits [7:2].
    logic [31:0] tb_mem [0:63];
    logic        preload;
    logic        m_in_burst = 1'b0;
    logic [31:0] m_ptr = 32'd0;

    always @(posedge clock) begin
        if (preload) begin
            for (int i = 1; i < 64; i++) tb_mem[i] <= 32'hA000_0000 + 32'(i);
            tb_mem[0] <= 32'h55cc_55cc;
        end
        if (!mem_enable) m_in_burst <= 1'b0;
        else if (mem_wren) tb_mem[mem_addr[7:2]] <= mem_data_in;
        else if (!m_in_burst) begin
            m_in_burst <= 1'b1;
            m_ptr      <= mem_addr;
        end else if (!mem_busy) m_ptr <= m_ptr + 32'd4;
    end

    assign mem_data_out = (m_in_burst && mem_enable) ? tb_mem[m_ptr[7:2]] : 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_resp(input int budget, output int t);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (if_gnt || d_gnt || if_err || d_err) begin
                hit = 1'b1;
                break;
            end
        end
        t = cyc;
        chk1("resp_timeout", hit, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t, tp, k, nrv;
        logic [1:0] gv;
        reset_n = 1'b0; preload = 1'b1; mem_busy = 1'b0;
        if_req = 1'b0; if_addr = '0; if_acc_size = '0;
        d_req = 1'b0; d_wren = 1'b0; d_addr = '0; d_acc_size = '0; d_wdata = '0;
        nclk(2);
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_mem_en", mem_enable, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        preload = 1'b0;
        reset_n = 1'b1;

        // 1: single-word IF read
        if_req = 1'b1; if_addr = BASE; if_acc_size = 2'b00;
        wait_resp(4, t);
        chk1("t1_if_gnt", if_gnt, 1'b1);
        chk1("t1_mem_en", mem_enable, 1'b1);
        chk("t1_mem_addr", mem_addr, BASE);
        chk1("t1_rvalid_T", if_rvalid, 1'b0);
        if_req = 1'b0;
        nclk(1);
        chk1("t1_rvalid_T1", if_rvalid, 1'b1);
        chk("t1_data", rsp_data, 32'h55cc_55cc);
        chk1("t1_d_rvalid", d_rvalid, 1'b0);
        nclk(1);
        chk1("t1_rvalid_T2", if_rvalid, 1'b0);
        chk1("t1_mem_en_T2", mem_enable, 1'b0);

        // 2: four D writes, then a 4-word D read
        tp = 0;
        for (int i = 0; i < 4; i++) begin
            d_req = 1'b1; d_wren = 1'b1; d_acc_size = 2'b11;
            d_addr = BASE + 32'(4 * i); d_wdata = 32'h55cc_55cc + 32'(i);
            wait_resp(4, t);
            chk1("t2_wr_gnt", d_gnt, 1'b1);
            chk1("t2_wr_wren", mem_wren, 1'b1);
            chk("t2_wr_data", mem_data_in, 32'h55cc_55cc + 32'(i));
            chk("t2_wr_size", 32'(mem_acc_size), 32'd0);
            if (i > 0) chk("t2_wr_gap", 32'(t - tp), 32'd2);
            tp = t;
            d_req = 1'b0; d_wren = 1'b0;
            nclk(1);
            chk1("t2_wr_en_off", mem_enable, 1'b0);
        end
        d_req = 1'b1; d_addr = BASE; d_acc_size = 2'b01;
        wait_resp(4, t);
        chk1("t2_rd_gnt", d_gnt, 1'b1);
        chk("t2_rd_size", 32'(mem_acc_size), 32'd1);
        d_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nclk(1);
            chk1("t2_d_rvalid", d_rvalid, 1'b1);
            chk1("t2_if_rvalid", if_rvalid, 1'b0);
            chk("t2_rd_data", rsp_data, 32'h55cc_55cc + 32'(i));
        end
        nclk(1);
        chk1("t2_d_rvalid_end", d_rvalid, 1'b0);
        chk1("t2_mem_en_end", mem_enable, 1'b0);

        // idle hold while mainMem is busy
        mem_busy = 1'b1; if_req = 1'b1; if_addr = BASE; if_acc_size = 2'b00;
        for (int i = 0; i < 3; i++) begin
            nclk(1);
            chk1("busy_no_gnt", if_gnt, 1'b0);
        end
        mem_busy = 1'b0;
        wait_resp(4, t);
        chk1("busy_then_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        nclk(2);

        // 3: simultaneous requests from reset alternate IF, D, IF
        reset_n = 1'b0;
        nclk(1);
        reset_n = 1'b1;
        if_req = 1'b1; if_addr = BASE; if_acc_size = 2'b00;
        d_req = 1'b1; d_wren = 1'b0; d_addr = BASE + 32'd4; d_acc_size = 2'b00;
        tp = 0;
        for (int g = 0; g < 3; g++) begin
            wait_resp(8, t);
            gv = {if_gnt, d_gnt};
            chk("t3_order", 32'(gv), (g == 1) ? 32'd1 : 32'd2);
            if (g > 0) chk("t3_gap", 32'(t - tp), 32'd3);
            tp = t;
        end
        if_req = 1'b0; d_req = 1'b0;
        nclk(2);

        // 4: rejected requests
        d_req = 1'b1; d_wren = 1'b0; d_addr = 32'h8002_0002; d_acc_size = 2'b00;
        wait_resp(4, t);
        chk1("t4_err_misal", d_err, 1'b1);
        chk1("t4_gnt_misal", d_gnt, 1'b0);
        chk1("t4_en_misal", mem_enable, 1'b0);
        d_req = 1'b0;
        nclk(1);
        chk1("t4_err_pulse", d_err, 1'b0);
        d_req = 1'b1; d_addr = 32'h8001_fffc;
        wait_resp(4, t);
        chk1("t4_err_low", d_err, 1'b1);
        chk1("t4_gnt_low", d_gnt, 1'b0);
        d_req = 1'b0;
        nclk(1);
        chk1("t4_err_low_pulse", d_err, 1'b0);
        chk1("t4_en_low", mem_enable, 1'b0);
        if_req = 1'b1; if_addr = 32'h8011_ffc4; if_acc_size = 2'b11;
        wait_resp(4, t);
        chk1("t4_err_top_burst", if_err, 1'b1);
        chk1("t4_gnt_top_burst", if_gnt, 1'b0);
        if_req = 1'b0;
        nclk(1);
        d_req = 1'b1; d_wren = 1'b1; d_addr = 32'h8012_0000; d_acc_size = 2'b00; d_wdata = 32'h1234_5678;
        wait_resp(4, t);
        chk1("t4_err_top_wr", d_err, 1'b1);
        d_req = 1'b0; d_wren = 1'b0;
        nclk(1);

        // 5: 16-word read ending at the last valid word, stalled at word 5
        if_req = 1'b1; if_addr = 32'h8011_ffc0; if_acc_size = 2'b11;
        wait_resp(4, t);
        chk1("t5_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        k = 0; nrv = 0;
        for (int c = 1; c <= 18; c++) begin
            nclk(1);
            if (if_rvalid) nrv++;
            chk1("t5_rvalid", if_rvalid, !(c == 6 || c == 7));
            if (!(c == 6 || c == 7)) begin
                chk("t5_data", rsp_data, 32'hA000_0030 + 32'(k));
                k++;
            end
            mem_busy = (c + 1 == 6) || (c + 1 == 7);
        end
        chk("t5_count", 32'(nrv), 32'd16);
        nclk(1);
        chk1("t5_rvalid_end", if_rvalid, 1'b0);
        chk1("t5_mem_en_end", mem_enable, 1'b0);

        // 6: reset in the middle of a 4-word read
        if_req = 1'b1; if_addr = BASE; if_acc_size = 2'b01;
        wait_resp(4, t);
        if_req = 1'b0;
        nclk(1);
        chk1("t6_rvalid_T1", if_rvalid, 1'b1);
        chk("t6_data_T1", rsp_data, 32'h55cc_55cc);
        nclk(1);
        reset_n = 1'b0;
        #1;
        chk1("t6_rst_rvalid", if_rvalid, 1'b0);
        chk1("t6_rst_mem_en", mem_enable, 1'b0);
        chk("t6_rst_mem_addr", mem_addr, 32'd0);
        chk("t6_rst_size", 32'(mem_acc_size), 32'd0);
        chk("t6_rst_data", rsp_data, 32'd0);
        nclk(1);
        reset_n = 1'b1;
        nclk(1);
        chk1("t6_no_stale", if_rvalid, 1'b0);
        if_req = 1'b1; if_addr = BASE + 32'd4; if_acc_size = 2'b00;
        wait_resp(4, t);
        chk1("t6_regrant", if_gnt, 1'b1);
        if_req = 1'b0;
        nclk(1);
        chk1("t6_rvalid", if_rvalid, 1'b1);
        chk("t6_data", rsp_data, 32'h55cc_55cd);
        nclk(1);
        chk1("t6_rvalid_end", if_rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
